// File: rtl/apo_router_circ_buf.sv
// apo_router_circ_buf: buffered router node for a circulant NoC C(N_NODES; S1, S1+1).
// Five input FIFOs (local core + four neighbours), a round-robin arbiter and an output
// register per output (four neighbours + local eject). Valid/ready on every port.
// Optional statistics counters are enabled by defining APO_ROUTER_STATS_EN.
module apo_router_circ_buf #(
    parameter int unsigned N_NODES = 196,
    parameter int unsigned S1      = 9,
    parameter int unsigned ID_W    = 8,
    parameter int unsigned STEP_W  = 8,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_W-1:0]       router_name,
    input  logic [ID_W-1:0]       in_free_data,
    input  logic                  in_free_valid,
    output logic                  in_free_ready,
    input  logic [2*STEP_W-1:0]   in_r1R_data,
    input  logic                  in_r1R_valid,
    output logic                  in_r1R_ready,
    input  logic [2*STEP_W-1:0]   in_r2R_data,
    input  logic                  in_r2R_valid,
    output logic                  in_r2R_ready,
    input  logic [2*STEP_W-1:0]   in_r1L_data,
    input  logic                  in_r1L_valid,
    output logic                  in_r1L_ready,
    input  logic [2*STEP_W-1:0]   in_r2L_data,
    input  logic                  in_r2L_valid,
    output logic                  in_r2L_ready,
    output logic [2*STEP_W-1:0]   out_r1R_data,
    output logic                  out_r1R_valid,
    input  logic                  out_r1R_ready,
    output logic [2*STEP_W-1:0]   out_r2R_data,
    output logic                  out_r2R_valid,
    input  logic                  out_r2R_ready,
    output logic [2*STEP_W-1:0]   out_r1L_data,
    output logic                  out_r1L_valid,
    input  logic                  out_r1L_ready,
    output logic [2*STEP_W-1:0]   out_r2L_data,
    output logic                  out_r2L_valid,
    input  logic                  out_r2L_ready,
    output logic                  out_data_valid,
    input  logic                  out_data_ready,
    output logic                  drop_err
`ifdef APO_ROUTER_STATS_EN
    ,
    output logic [31:0]           fwd_count,
    output logic [31:0]           eject_count,
    output logic [15:0]           drop_count
`endif
);

    localparam int unsigned FW = 2 * STEP_W;
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned NP = 5;
    localparam int unsigned KW = ID_W + 1;
    localparam int unsigned SW = ID_W + 2;
    localparam logic signed [SW-1:0] S1_S  = SW'(S1);
    localparam logic signed [SW-1:0] S1P_S = SW'(S1 + 1);

    // Ring distance -> minimal (r1, r2) step pair, signed toward the destination.
    function automatic logic [FW-1:0] local_route(input logic [ID_W-1:0] s, input logic [ID_W-1:0] nm);
        logic [KW-1:0] k, q, b;
        logic sgn;
        logic signed [SW-1:0] a, bb, r1, r2;
        if (s < nm) begin
            k = {1'b0, nm} - {1'b0, s};
            sgn = 1'b1;
        end else begin
            k = {1'b0, s} - {1'b0, nm};
            sgn = 1'b0;
        end
        if (k > KW'(N_NODES / 2)) begin
            k = KW'(N_NODES) - k;
            sgn = ~sgn;
        end
        q  = k / KW'(S1);
        b  = k % KW'(S1);
        a  = $signed({1'b0, q}) - $signed({1'b0, b});
        bb = $signed({1'b0, b});
        if (a >= bb - S1_S && a <= S1_S) begin
            r1 = a;
            r2 = bb;
        end else if (a < bb - S1_S) begin
            r1 = a + S1P_S;
            r2 = bb - S1_S;
        end else begin
            r1 = a - S1P_S;
            r2 = bb + S1_S;
        end
        if (sgn) begin
            r1 = -r1;
            r2 = -r2;
        end
        return {STEP_W'(r1), STEP_W'(r2)};
    endfunction

    // Output port (0 r1R, 1 r2R, 2 r1L, 3 r2L, 4 eject) and the decremented flit.
    function automatic logic [FW+2:0] port_sel(input logic [FW-1:0] f);
        logic signed [STEP_W-1:0] r1, r2;
        r1 = $signed(f[FW-1:STEP_W]);
        r2 = $signed(f[STEP_W-1:0]);
        if (r1 > 0)      return {3'd0, STEP_W'(r1 - 1), r2};
        else if (r1 < 0) return {3'd2, STEP_W'(r1 + 1), r2};
        else if (r2 > 0) return {3'd1, r1, STEP_W'(r2 - 1)};
        else if (r2 < 0) return {3'd3, r1, STEP_W'(r2 + 1)};
        else             return {3'd4, r1, r2};
    endfunction

    function automatic logic [2:0] rr_idx(input logic [2:0] p, input int off);
        int s;
        s = int'(p) + off;
        if (s >= int'(NP)) s = s - int'(NP);
        return 3'(s);
    endfunction

    logic [FW-1:0]  in_data [NP];
    logic [NP-1:0]  in_valid, rdy_q, push, pop, head_vis, wr_last;
    logic [FW-1:0]  mem [NP][DEPTH];
    logic [AW-1:0]  wptr [NP];
    logic [AW-1:0]  rptr [NP];
    logic [AW:0]    cnt [NP];
    logic [AW:0]    cnt_nxt [NP];
    logic [FW-1:0]  head [NP];
    logic [2:0]     port [NP];
    logic [FW-1:0]  nflit [NP];
    logic [NP-1:0]  req [NP];
    logic [NP-1:0]  gnt_v, load_ok, o_ready, ov;
    logic [2:0]     gidx [NP];
    logic [2:0]     ptr [NP];
    logic [FW-1:0]  od [4];
    logic           drop_now, drop_q;

    assign in_data[0] = FW'(in_free_data);
    assign in_data[1] = in_r1R_data;
    assign in_data[2] = in_r2R_data;
    assign in_data[3] = in_r1L_data;
    assign in_data[4] = in_r2L_data;
    assign in_valid   = {in_r2L_valid, in_r1L_valid, in_r2R_valid, in_r1R_valid, in_free_valid};
    assign o_ready    = {out_data_ready, out_r2L_ready, out_r1L_ready, out_r2R_ready, out_r1R_ready};
    assign push       = in_valid & rdy_q;
    assign load_ok    = ~ov | o_ready;

    // FIFO occupancy bookkeeping and head visibility (newest entry hidden for one route cycle).
    always_comb begin
        for (int i = 0; i < int'(NP); i++) begin
            cnt_nxt[i]  = cnt[i] + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
            head[i]     = mem[i][rptr[i]];
            head_vis[i] = (cnt[i] != '0) && !(cnt[i] == (AW+1)'(1) && wr_last[i]);
        end
    end

    // FIFO pointers, counts and registered ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NP); i++) begin
                wptr[i] <= '0;
                rptr[i] <= '0;
                cnt[i]  <= '0;
            end
            wr_last <= '0;
            rdy_q   <= '0;
        end else begin
            for (int i = 0; i < int'(NP); i++) begin
                if (push[i]) wptr[i] <= wptr[i] + AW'(1);
                if (pop[i])  rptr[i] <= rptr[i] + AW'(1);
                cnt[i]     <= cnt_nxt[i];
                rdy_q[i]   <= (cnt_nxt[i] != (AW+1)'(DEPTH));
            end
            wr_last <= push;
        end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(NP); i++)
            if (push[i]) mem[i][wptr[i]] <= in_data[i];
    end

    // Route compute on every head and request vectors per output.
    always_comb begin
        drop_now = head_vis[0] && ({1'b0, head[0][ID_W-1:0]} >= KW'(N_NODES));
        {port[0], nflit[0]} = port_sel(local_route(head[0][ID_W-1:0], router_name));
        for (int i = 1; i < int'(NP); i++) {port[i], nflit[i]} = port_sel(head[i]);
        for (int o = 0; o < int'(NP); o++)
            for (int i = 0; i < int'(NP); i++)
                req[o][i] = head_vis[i] && (port[i] == 3'(o)) && !(i == 0 && drop_now);
    end

    // Round-robin grant per output, only when its register can load.
    always_comb begin
        pop = '0;
        pop[0] = drop_now;
        for (int o = 0; o < int'(NP); o++) begin
            gnt_v[o] = 1'b0;
            gidx[o]  = '0;
            for (int off = 0; off < int'(NP); off++) begin
                if (!gnt_v[o] && load_ok[o] && req[o][rr_idx(ptr[o], off)]) begin
                    gnt_v[o] = 1'b1;
                    gidx[o]  = rr_idx(ptr[o], off);
                end
            end
            if (gnt_v[o]) pop[gidx[o]] = 1'b1;
        end
    end

    // Output registers, arbiter pointers and drop pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ov     <= '0;
            drop_q <= 1'b0;
            for (int o = 0; o < int'(NP); o++) ptr[o] <= '0;
            for (int o = 0; o < 4; o++) od[o] <= '0;
        end else begin
            for (int o = 0; o < int'(NP); o++) begin
                if (gnt_v[o]) begin
                    ov[o]  <= 1'b1;
                    ptr[o] <= rr_idx(gidx[o], 1);
                end else if (o_ready[o]) begin
                    ov[o]  <= 1'b0;
                end
            end
            for (int o = 0; o < 4; o++)
                if (gnt_v[o]) od[o] <= nflit[gidx[o]];
            drop_q <= drop_now;
        end
    end

    assign in_free_ready  = rdy_q[0];
    assign in_r1R_ready   = rdy_q[1];
    assign in_r2R_ready   = rdy_q[2];
    assign in_r1L_ready   = rdy_q[3];
    assign in_r2L_ready   = rdy_q[4];
    assign out_r1R_data   = od[0];
    assign out_r2R_data   = od[1];
    assign out_r1L_data   = od[2];
    assign out_r2L_data   = od[3];
    assign out_r1R_valid  = ov[0];
    assign out_r2R_valid  = ov[1];
    assign out_r1L_valid  = ov[2];
    assign out_r2L_valid  = ov[3];
    assign out_data_valid = ov[4];
    assign drop_err       = drop_q;

`ifdef APO_ROUTER_STATS_EN
    logic [2:0] fwd_n;

    // Number of neighbour-output transfers this cycle.
    always_comb begin
        fwd_n = '0;
        for (int o = 0; o < 4; o++) fwd_n = fwd_n + 3'(ov[o] & o_ready[o]);
    end

    // Saturating statistics counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_count   <= '0;
            eject_count <= '0;
            drop_count  <= '0;
        end else begin
            if (fwd_count > 32'hFFFF_FFFF - 32'(fwd_n)) fwd_count <= '1;
            else                                        fwd_count <= fwd_count + 32'(fwd_n);
            if (ov[4] && o_ready[4] && eject_count != '1) eject_count <= eject_count + 32'd1;
            if (drop_now && drop_count != '1)             drop_count  <= drop_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_apo_router_circ_buf.sv
// Directed self-checking bench for apo_router_circ_buf (node 0 of C(196; 9, 10)).
module tb_apo_router_circ_buf;

    localparam int unsigned DEPTH = 4;

    logic        clk, rst;
    logic [7:0]  router_name, in_free_data;
    logic        in_free_valid, in_free_ready;
    logic [15:0] in_r1R_data, in_r2R_data, in_r1L_data, in_r2L_data;
    logic        in_r1R_valid, in_r2R_valid, in_r1L_valid, in_r2L_valid;
    logic        in_r1R_ready, in_r2R_ready, in_r1L_ready, in_r2L_ready;
    logic [15:0] out_r1R_data, out_r2R_data, out_r1L_data, out_r2L_data;
    logic        out_r1R_valid, out_r2R_valid, out_r1L_valid, out_r2L_valid;
    logic        out_r1R_ready, out_r2R_ready, out_r1L_ready, out_r2L_ready;
    logic        out_data_valid, out_data_ready, drop_err;

    apo_router_circ_buf dut (
        .clk(clk), .rst(rst), .router_name(router_name),
        .in_free_data(in_free_data), .in_free_valid(in_free_valid), .in_free_ready(in_free_ready),
        .in_r1R_data(in_r1R_data), .in_r1R_valid(in_r1R_valid), .in_r1R_ready(in_r1R_ready),
        .in_r2R_data(in_r2R_data), .in_r2R_valid(in_r2R_valid), .in_r2R_ready(in_r2R_ready),
        .in_r1L_data(in_r1L_data), .in_r1L_valid(in_r1L_valid), .in_r1L_ready(in_r1L_ready),
        .in_r2L_data(in_r2L_data), .in_r2L_valid(in_r2L_valid), .in_r2L_ready(in_r2L_ready),
        .out_r1R_data(out_r1R_data), .out_r1R_valid(out_r1R_valid), .out_r1R_ready(out_r1R_ready),
        .out_r2R_data(out_r2R_data), .out_r2R_valid(out_r2R_valid), .out_r2R_ready(out_r2R_ready),
        .out_r1L_data(out_r1L_data), .out_r1L_valid(out_r1L_valid), .out_r1L_ready(out_r1L_ready),
        .out_r2L_data(out_r2L_data), .out_r2L_valid(out_r2L_valid), .out_r2L_ready(out_r2L_ready),
        .out_data_valid(out_data_valid), .out_data_ready(out_data_ready), .drop_err(drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_ej = 0;
    int n_drop = 0;
    logic [15:0] q_r1r [$];
    logic [15:0] exp_q [$];

    // Transfer monitor sampled at the active edge.
    always @(posedge clk) begin
        if (out_r1R_valid && out_r1R_ready) q_r1r.push_back(out_r1R_data);
        if (out_data_valid && out_data_ready) n_ej <= n_ej + 1;
        if (drop_err) n_drop <= n_drop + 1;
    end

    wire any_valid = out_r1R_valid | out_r2R_valid | out_r1L_valid | out_r2L_valid | out_data_valid;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_free(input logic [7:0] d);
        in_free_data  = d;
        in_free_valid = 1'b1;
        tick();
        in_free_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ej0, d0, sz, waited;
        rst = 1'b1; router_name = 8'd0;
        in_free_data = '0; in_free_valid = 1'b0;
        in_r1R_data = '0; in_r2R_data = '0; in_r1L_data = '0; in_r2L_data = '0;
        in_r1R_valid = 1'b0; in_r2R_valid = 1'b0; in_r1L_valid = 1'b0; in_r2L_valid = 1'b0;
        out_r1R_ready = 1'b1; out_r2R_ready = 1'b1; out_r1L_ready = 1'b1; out_r2L_ready = 1'b1;
        out_data_ready = 1'b1;

        // reset state
        tick();
        chk("rst_valid", 32'(any_valid), 0);
        chk("rst_data", 32'(out_r1R_data), 0);
        chk("rst_drop", 32'(drop_err), 0);
        chk("rst_free_rdy", 32'(in_free_ready), 0);
        chk("rst_r1R_rdy", 32'(in_r1R_ready), 0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_rdy", 32'({in_free_ready, in_r1R_ready, in_r2R_ready, in_r1L_ready, in_r2L_ready}), 32'h1F);

        // dst=20 -> r2R {0,1}, presented after t+2
        send_free(8'd20);
        chk("d20_t1_valid", 32'(out_r2R_valid), 0);
        tick();
        chk("d20_t1b_valid", 32'(out_r2R_valid), 0);
        tick();
        chk("d20_t2_valid", 32'(out_r2R_valid), 1);
        chk("d20_t2_data", 32'(out_r2R_data), 32'h0001);
        tick();
        chk("d20_done", 32'(out_r2R_valid), 0);

        // dst=190 -> k=6, (r1,r2)=(-4,3) -> r1L {-3,3}
        send_free(8'd190);
        tick();
        chk("d190_t1_valid", 32'(out_r1L_valid), 0);
        tick();
        chk("d190_valid", 32'(out_r1L_valid), 1);
        chk("d190_data", 32'(out_r1L_data), 32'hFD03);
        tick();

        // eject with backpressure held for three cycles
        out_data_ready = 1'b0;
        ej0 = n_ej;
        in_r1L_data = 16'h0000; in_r1L_valid = 1'b1;
        tick();
        in_r1L_valid = 1'b0;
        tick();
        tick();
        chk("ej_valid_h0", 32'(out_data_valid), 1);
        tick();
        chk("ej_valid_h1", 32'(out_data_valid), 1);
        tick();
        chk("ej_valid_h2", 32'(out_data_valid), 1);
        out_data_ready = 1'b1;
        tick();
        chk("ej_done", 32'(out_data_valid), 0);
        chk("ej_count", 32'(n_ej - ej0), 1);

        // dst=196 -> single drop pulse, nothing emitted
        d0 = n_drop;
        send_free(8'd196);
        chk("drop_t0", 32'(drop_err), 0);
        tick();
        chk("drop_t1", 32'(drop_err), 0);
        tick();
        chk("drop_t2", 32'(drop_err), 1);
        tick();
        chk("drop_t3", 32'(drop_err), 0);
        chk("drop_no_valid", 32'(any_valid), 0);
        chk("drop_count", 32'(n_drop - d0), 1);
        chk("drop_free_rdy", 32'(in_free_ready), 1);

        // contention on r1R: fill all FIFOs while stalled, then drain round-robin
        out_r1R_ready = 1'b0;
        sz = q_r1r.size();
        for (int j = 0; j < int'(DEPTH); j++) begin
            in_free_valid = (j == 0);
            in_free_data  = 8'd27;
            in_r1R_data = {8'd3, 8'(1 + j)};  in_r1R_valid = 1'b1;
            in_r2R_data = {8'd3, 8'(5 + j)};  in_r2R_valid = 1'b1;
            in_r1L_data = {8'd3, 8'(9 + j)};  in_r1L_valid = 1'b1;
            in_r2L_data = {8'd3, 8'(13 + j)}; in_r2L_valid = 1'b1;
            tick();
        end
        in_free_valid = 1'b0;
        in_r1R_valid = 1'b0; in_r2R_valid = 1'b0; in_r1L_valid = 1'b0; in_r2L_valid = 1'b0;
        chk("full_rdy", 32'({in_r1R_ready, in_r2R_ready, in_r1L_ready, in_r2L_ready}), 0);
        chk("full_free_rdy", 32'(in_free_ready), 1);
        tick();
        tick();
        chk("stall_valid", 32'(out_r1R_valid), 1);
        chk("stall_data", 32'(out_r1R_data), 32'h0200);
        exp_q.push_back(16'h0200);
        for (int j = 0; j < int'(DEPTH); j++)
            for (int p = 0; p < 4; p++)
                exp_q.push_back({8'd2, 8'(1 + p * 4 + j)});
        out_r1R_ready = 1'b1;
        waited = 0;
        while (q_r1r.size() - sz < 4 * int'(DEPTH) + 1 && waited < 60) begin
            tick();
            waited++;
        end
        chk("drain_count", 32'(q_r1r.size() - sz), 32'(4 * DEPTH + 1));
        for (int n = 0; n < exp_q.size() && sz + n < q_r1r.size(); n++)
            chk($sformatf("drain_%0d", n), 32'(q_r1r[sz + n]), 32'(exp_q[n]));
        tick();
        chk("drain_rdy", 32'({in_r1R_ready, in_r2R_ready, in_r1L_ready, in_r2L_ready}), 32'hF);

        // reset with three flits buffered flushes everything
        out_r1R_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            in_r1R_data = {8'd3, 8'(j)}; in_r1R_valid = 1'b1;
            tick();
        end
        in_r1R_valid = 1'b0;
        tick();
        tick();
        chk("pre_rst_valid", 32'(out_r1R_valid), 1);
        sz = q_r1r.size();
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(any_valid), 0);
        chk("mid_rst_rdy", 32'(in_r1R_ready), 0);
        tick();
        rst = 1'b0;
        out_r1R_ready = 1'b1;
        repeat (10) tick();
        chk("post_flush_none", 32'(q_r1r.size() - sz), 0);
        chk("post_flush_valid", 32'(any_valid), 0);
        chk("post_flush_rdy", 32'(in_r1R_ready), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
